buzzer_music_player: RTL



---
 rtl/buzzer_pkg.sv | 64 ++++++
 rtl/buzzer_song_rom.sv | 16 +
 rtl/buzzer_music_player.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/buzzer_pkg.sv
// Shared types, pitch table and song contents for the buzzer music player.
package buzzer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP
  } state_t;

  typedef struct packed {
    logic [4:0] pitch;
    logic [2:0] dur;
  } rom_entry_t;

  localparam logic [4:0] PITCH_REST = 5'd0;
  localparam logic [4:0] PITCH_END  = 5'd31;

  // Reference clock the half-period table below was computed for.
  localparam int unsigned HP_REF_CLK_HZ = 50_000_000;

  // round(50 MHz / (2 * f)) for MIDI note 59+pitch; entry 0 is the rest slot.
  localparam logic [16:0] HALF_PERIOD_50M [31] = '{
    17'd0,
    17'd95556, 17'd90193, 17'd85131, 17'd80353, 17'd75843, 17'd71586,
    17'd67569, 17'd63776, 17'd60197, 17'd56818, 17'd53629, 17'd50619,
    17'd47778, 17'd45097, 17'd42566, 17'd40177, 17'd37922, 17'd35793,
    17'd33784, 17'd31888, 17'd30098, 17'd28409, 17'd26815, 17'd25310,
    17'd23889, 17'd22548, 17'd21283, 17'd20088, 17'd18961, 17'd17897
  };

  // Song 0 is unused and reads as an immediate end marker.
  localparam logic [7:0] SONG_0 [32] = '{default: 8'hF8};

  // A4 for two beats, a one-beat rest, end.
  localparam logic [7:0] SONG_1 [32] = '{0: 8'h51, 1: 8'h00, default: 8'hF8};

  // Full 32-entry song with no end marker: one-beat notes climbing C4..F6, then C4, C#4.
  localparam logic [7:0] SONG_2 [32] = '{
    8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'h40,
    8'h48, 8'h50, 8'h58, 8'h60, 8'h68, 8'h70, 8'h78, 8'h80,
    8'h88, 8'h90, 8'h98, 8'hA0, 8'hA8, 8'hB0, 8'hB8, 8'hC0,
    8'hC8, 8'hD0, 8'hD8, 8'hE0, 8'hE8, 8'hF0, 8'h08, 8'h10
  };

  // Twinkle twinkle, first phrase.
  localparam logic [7:0] SONG_3 [32] = '{
    0: 8'h08, 1: 8'h08, 2: 8'h40, 3: 8'h40, 4: 8'h50, 5: 8'h50, 6: 8'h41,
    7: 8'h30, 8: 8'h30, 9: 8'h28, 10: 8'h28, 11: 8'h18, 12: 8'h18, 13: 8'h09,
    default: 8'hF8
  };

  function automatic rom_entry_t song_entry(input logic [1:0] song, input logic [4:0] idx);
    logic [7:0] raw;
    case (song)
      2'd1:    raw = SONG_1[idx];
      2'd2:    raw = SONG_2[idx];
      2'd3:    raw = SONG_3[idx];
      default: raw = SONG_0[idx];
    endcase
    return rom_entry_t'(raw);
  endfunction

endpackage

// File: rtl/buzzer_song_rom.sv
// Synchronous-read song ROM, address {song, idx}.
module buzzer_song_rom
  import buzzer_pkg::*;
(
  input  logic       HCLK,
  input  logic [1:0] song,
  input  logic [4:0] idx,
  output rom_entry_t data
);

  // Registered lookup; data is valid the cycle after the address is presented.
  always_ff @(posedge HCLK) begin
    data <= song_entry(song, idx);
  end

endmodule

// File: rtl/buzzer_music_player.sv
// Buzzer music sequencer: walks a song ROM, plays each note as a square wave,
// then inserts a short silent gap.
//
// state   | meaning
// IDLE    | silent, waiting for a start command
// FETCH   | one cycle while the ROM entry for note_idx is read
// PLAY    | note (or rest) sounding for (dur+1)*BEAT_TICKS cycles
// GAP     | forced silence for GAP_TICKS cycles between notes
module buzzer_music_player
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BEAT_TICKS = 6_250_000,
  parameter int unsigned GAP_TICKS  = 500_000,
  parameter int unsigned TONE_SHIFT = 0
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [1:0] music_select,
  input  logic       music_start,
  output logic       buzzer_out,
  output logic       busy,
  output logic       song_done,
  output logic [4:0] note_idx
);

  state_t      state, state_nxt;
  rom_entry_t  rom_q;
  logic [1:0]  song, song_nxt;
  logic [4:0]  idx_nxt;
  logic        start_song, end_song, next_note;
  logic [31:0] dur_cnt, gap_cnt, dur_load;
  logic [16:0] tone_cnt, half_q, hp_fetch;
  logic        rest_q;
  logic [16:0] hp_lut [32];

  // Half-period lookup, rescaled to CLK_HZ and shifted at elaboration; never 0.
  for (genvar gi = 0; gi < 32; gi++) begin : g_hp
    if (gi < 31) begin : g_note
      localparam longint unsigned SCALED =
        (64'(HALF_PERIOD_50M[gi]) * 64'(CLK_HZ)) / 64'(HP_REF_CLK_HZ);
      localparam longint unsigned SHIFTED = SCALED >> TONE_SHIFT;
      assign hp_lut[gi] = (SHIFTED == 64'd0) ? 17'd1 : 17'(SHIFTED);
    end else begin : g_end
      assign hp_lut[gi] = 17'd1;
    end
  end

  // The ROM is addressed with next-cycle song/index so FETCH sees fresh data.
  buzzer_song_rom u_rom (
    .HCLK (HCLK),
    .song (song_nxt),
    .idx  (idx_nxt),
    .data (rom_q)
  );

  assign hp_fetch = hp_lut[rom_q.pitch];
  assign dur_load = (32'(rom_q.dur) + 32'd1) * BEAT_TICKS - 32'd1;

  // State register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a start command overrides every internal transition.
  always_comb begin
    state_nxt = state;
    if (music_start) begin
      state_nxt = (music_select != 2'd0) ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_FETCH: state_nxt = (rom_q.pitch == PITCH_END) ? S_IDLE : S_PLAY;
        S_PLAY:  if (dur_cnt == 32'd0) state_nxt = S_GAP;
        S_GAP:   if (gap_cnt == 32'd0) state_nxt = (note_idx == 5'd31) ? S_IDLE : S_FETCH;
        default: state_nxt = state;
      endcase
    end
  end

  // Output decode: next song/index and the natural end-of-song condition.
  always_comb begin
    start_song = music_start && (music_select != 2'd0);
    end_song   = 1'b0;
    next_note  = 1'b0;
    if (!music_start) begin
      end_song  = ((state == S_FETCH) && (rom_q.pitch == PITCH_END)) ||
                  ((state == S_GAP) && (gap_cnt == 32'd0) && (note_idx == 5'd31));
      next_note = (state == S_GAP) && (gap_cnt == 32'd0) && (note_idx != 5'd31);
    end
    song_nxt = start_song ? music_select : song;
    idx_nxt  = note_idx;
    if (music_start)    idx_nxt = 5'd0;
    else if (next_note) idx_nxt = note_idx + 5'd1;
  end

  // Registered outputs, duration/gap/tone down-counters and the square wave.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      song       <= 2'd0;
      note_idx   <= 5'd0;
      busy       <= 1'b0;
      song_done  <= 1'b0;
      buzzer_out <= 1'b0;
      dur_cnt    <= 32'd0;
      gap_cnt    <= 32'd0;
      tone_cnt   <= 17'd0;
      half_q     <= 17'd0;
      rest_q     <= 1'b0;
    end else begin
      song      <= song_nxt;
      note_idx  <= idx_nxt;
      busy      <= (state_nxt != S_IDLE);
      song_done <= end_song;
      if (music_start) begin
        buzzer_out <= 1'b0;
        dur_cnt    <= 32'd0;
        gap_cnt    <= 32'd0;
        tone_cnt   <= 17'd0;
      end else begin
        case (state)
          S_FETCH: begin
            buzzer_out <= 1'b0;
            dur_cnt    <= dur_load;
            tone_cnt   <= hp_fetch - 17'd1;
            half_q     <= hp_fetch;
            rest_q     <= (rom_q.pitch == PITCH_REST);
          end
          S_PLAY: begin
            if (dur_cnt == 32'd0) begin
              buzzer_out <= 1'b0;
              gap_cnt    <= GAP_TICKS - 32'd1;
            end else begin
              dur_cnt <= dur_cnt - 32'd1;
              if (tone_cnt == 17'd0) begin
                tone_cnt <= half_q - 17'd1;
                if (!rest_q) buzzer_out <= ~buzzer_out;
              end else begin
                tone_cnt <= tone_cnt - 17'd1;
              end
            end
          end
          S_GAP: begin
            buzzer_out <= 1'b0;
            if (gap_cnt != 32'd0) gap_cnt <= gap_cnt - 32'd1;
          end
          default: buzzer_out <= 1'b0;
        endcase
      end
    end
  end

endmodule
